// File: rtl/dac_frame_scheduler_pkg.sv
// Shared definitions for the DAC frame scheduler: channel count and FSM encoding.
package dac_frame_scheduler_pkg;

    localparam int NUM_DAC_CH = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_BUSY      = 3'd3,
        ST_HOLDOFF   = 3'd4
    } dac_state_t;

endpackage

// File: rtl/dac_frame_scheduler_holder.sv
// One channel's sample holding register with a pending flag and an overwrite strobe.
module dac_sample_holder #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic              clear,
    output logic [DATA_W-1:0] sample,
    output logic              pending,
    output logic              overrun
);

    // A sample arriving while the old one is being snapshotted is not an overwrite.
    assign overrun = valid & pending & ~clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample  <= '0;
            pending <= 1'b0;
        end else begin
            if (valid) begin
                sample  <= data;
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Collects per-channel samples and launches 4-channel frames to a serial DAC driver,
// with busy handshake, launch timeout, post-frame hold-off and overrun accounting.
module dac_frame_scheduler
    import dac_frame_scheduler_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 255,
    parameter int OFFSET_BIN  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [3:0]        ch_mask,
    input  logic [15:0]       min_interval,
    input  logic [DATA_W-1:0] ch0_data,
    input  logic [DATA_W-1:0] ch1_data,
    input  logic [DATA_W-1:0] ch2_data,
    input  logic [DATA_W-1:0] ch3_data,
    input  logic              ch0_valid,
    input  logic              ch1_valid,
    input  logic              ch2_valid,
    input  logic              ch3_valid,
    input  logic              dac_busy,
    output logic              dac_start,
    output logic [DATA_W-1:0] dac0_datain,
    output logic [DATA_W-1:0] dac1_datain,
    output logic [DATA_W-1:0] dac2_datain,
    output logic [DATA_W-1:0] dac3_datain,
    output logic [31:0]       frame_count,
    output logic [15:0]       overrun_count,
    output logic              timeout_err,
    output logic              state_idle
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    function automatic logic [DATA_W-1:0] to_dac(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        r = s;
        if (OFFSET_BIN != 0) r[DATA_W-1] = ~s[DATA_W-1];
        return r;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [2:0] inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + {14'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [DATA_W-1:0]     ch_data [NUM_DAC_CH];
    logic [DATA_W-1:0]     held    [NUM_DAC_CH];
    logic [DATA_W-1:0]     snap    [NUM_DAC_CH];
    logic [NUM_DAC_CH-1:0] ch_valid;
    logic [NUM_DAC_CH-1:0] pending;
    logic [NUM_DAC_CH-1:0] overrun;
    logic [2:0]            overrun_sum;

    dac_state_t  state, next_state;
    logic [31:0] cnt;
    logic        launch, timeout_hit, frame_done;

    assign ch_data[0] = ch0_data;
    assign ch_data[1] = ch1_data;
    assign ch_data[2] = ch2_data;
    assign ch_data[3] = ch3_data;
    assign ch_valid   = {ch3_valid, ch2_valid, ch1_valid, ch0_valid};

    for (genvar i = 0; i < NUM_DAC_CH; i++) begin : g_holder
        dac_sample_holder #(.DATA_W(DATA_W)) u_holder (
            .clk     (clk),
            .reset_n (reset_n),
            .valid   (ch_valid[i]),
            .data    (ch_data[i]),
            .clear   (launch),
            .sample  (held[i]),
            .pending (pending[i]),
            .overrun (overrun[i])
        );
    end

    assign overrun_sum = {2'b0, overrun[0]} + {2'b0, overrun[1]}
                       + {2'b0, overrun[2]} + {2'b0, overrun[3]};

    always_comb begin
        next_state  = state;
        launch      = 1'b0;
        timeout_hit = 1'b0;
        frame_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && |(pending & ch_mask)) begin
                    next_state = ST_LAUNCH;
                    launch     = 1'b1;
                end
            end
            ST_LAUNCH: next_state = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (dac_busy) begin
                    next_state = ST_BUSY;
                end else if (cnt == TIMEOUT_LAST) begin
                    next_state  = ST_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!dac_busy) begin
                    frame_done = 1'b1;
                    next_state = (min_interval != 16'd0) ? ST_HOLDOFF : ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                if (cnt == 32'd0) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // cnt counts up in WAIT_BUSY and down in HOLDOFF; BUSY keeps reloading it so
    // the hold-off length is whatever min_interval was on the exit cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            frame_count   <= '0;
            overrun_count <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= next_state;
            overrun_count <= sat_add(overrun_count, overrun_sum);
            if (frame_done)  frame_count <= frame_count + 32'd1;
            if (timeout_hit) timeout_err <= 1'b1;
            case (state)
                ST_LAUNCH:    cnt <= '0;
                ST_WAIT_BUSY: cnt <= cnt + 32'd1;
                ST_BUSY:      cnt <= {16'b0, min_interval} - 32'd1;
                ST_HOLDOFF:   cnt <= cnt - 32'd1;
                default:      cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DAC_CH; i++) snap[i] <= '0;
        end else if (launch) begin
            for (int i = 0; i < NUM_DAC_CH; i++) snap[i] <= held[i];
        end
    end

    assign dac_start   = (state == ST_LAUNCH);
    assign state_idle  = (state == ST_IDLE);
    assign dac0_datain = to_dac(snap[0]);
    assign dac1_datain = to_dac(snap[1]);
    assign dac2_datain = to_dac(snap[2]);
    assign dac3_datain = to_dac(snap[3]);

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Scoreboard bench for dac_frame_scheduler: expected frames are queued at stimulus
// time and compared by a monitor at every dac_start pulse.
module tb_dac_frame_scheduler;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [3:0]        ch_mask;
    logic [15:0]       min_interval;
    logic [DATA_W-1:0] d [4];
    logic              v [4];
    logic              dac_busy;
    logic              dac_start;
    logic [DATA_W-1:0] dac0_datain, dac1_datain, dac2_datain, dac3_datain;
    logic [31:0]       frame_count;
    logic [15:0]       overrun_count;
    logic              timeout_err;
    logic              state_idle;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q [$];
    int          starts [$];
    int          cyc = 0;
    int          busy_len = 40;
    bit          busy_en  = 1'b1;

    always #5 clk = ~clk;

    dac_frame_scheduler #(.DATA_W(16), .TIMEOUT_CYC(255), .OFFSET_BIN(1)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .ch_mask       (ch_mask),
        .min_interval  (min_interval),
        .ch0_data      (d[0]),
        .ch1_data      (d[1]),
        .ch2_data      (d[2]),
        .ch3_data      (d[3]),
        .ch0_valid     (v[0]),
        .ch1_valid     (v[1]),
        .ch2_valid     (v[2]),
        .ch3_valid     (v[3]),
        .dac_busy      (dac_busy),
        .dac_start     (dac_start),
        .dac0_datain   (dac0_datain),
        .dac1_datain   (dac1_datain),
        .dac2_datain   (dac2_datain),
        .dac3_datain   (dac3_datain),
        .frame_count   (frame_count),
        .overrun_count (overrun_count),
        .timeout_err   (timeout_err),
        .state_idle    (state_idle)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int ch, input logic [15:0] val);
        v[ch] = 1'b1;
        d[ch] = val;
        @(negedge clk);
        v[ch] = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] e);
        exp_q.push_back({e, c, b, a});
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frame_count != 32'(target); i++) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    // DAC driver model: busy rises the cycle after dac_start and stays high busy_len cycles.
    initial begin
        bit arm = 1'b0;
        int cnt = 0;
        dac_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                arm = 1'b0;
                cnt = 0;
                dac_busy = 1'b0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) dac_busy = 1'b0;
                end
                if (arm) begin
                    arm = 1'b0;
                    if (busy_en) begin
                        dac_busy = 1'b1;
                        cnt = busy_len;
                    end
                end
                if (dac_start) arm = 1'b1;
            end
        end
    end

    // Monitor: every launch pops one expected frame.
    initial begin
        logic        prev = 1'b0;
        logic [63:0] want;
        forever begin
            @(negedge clk);
            cyc++;
            if (dac_start) begin
                starts.push_back(cyc);
                check("start_one_cycle", {63'b0, prev}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_launch", 64'd1, 64'd0);
                end else begin
                    want = exp_q.pop_front();
                    check("frame_data", {dac3_datain, dac2_datain, dac1_datain, dac0_datain}, want);
                end
            end
            prev = dac_start;
        end
    end

    initial begin
        int n0;
        reset_n = 1'b0;
        enable = 1'b0;
        ch_mask = 4'b0000;
        min_interval = 16'd0;
        for (int i = 0; i < 4; i++) begin
            v[i] = 1'b0;
            d[i] = '0;
        end
        tick(2);
        check("rst_dac", {dac3_datain, dac2_datain, dac1_datain, dac0_datain}, 64'h8000_8000_8000_8000);
        check("rst_start", {63'b0, dac_start}, 64'd0);
        check("rst_frames", {32'b0, frame_count}, 64'd0);
        check("rst_overrun", {48'b0, overrun_count}, 64'd0);
        check("rst_timeout", {63'b0, timeout_err}, 64'd0);
        check("rst_idle", {63'b0, state_idle}, 64'd1);
        reset_n = 1'b1;
        enable = 1'b1;
        ch_mask = 4'b0001;
        tick(2);

        // Test 1: single ch0 sample of zero
        push_frame(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        send(0, 16'h0000);
        check("t1_start_early", {63'b0, dac_start}, 64'd0);
        tick(1);
        check("t1_start_latency", {63'b0, dac_start}, 64'd1);
        wait_frames(1, 200);
        check("t1_frames", {32'b0, frame_count}, 64'd1);
        check("t1_dac0_stable", {48'b0, dac0_datain}, 64'h8000);

        // Test 2: three ch1 samples during one busy frame
        ch_mask = 4'b0010;
        push_frame(16'h8000, 16'h9111, 16'h8000, 16'h8000);
        send(1, 16'h1111);
        tick(1);
        check("t2_start", {63'b0, dac_start}, 64'd1);
        v[1] = 1'b1;
        d[1] = 16'h1234;
        tick(1);
        d[1] = 16'h2345;
        tick(1);
        d[1] = 16'h3456;
        tick(1);
        v[1] = 1'b0;
        push_frame(16'h8000, 16'hB456, 16'h8000, 16'h8000);
        wait_frames(3, 300);
        check("t2_frames", {32'b0, frame_count}, 64'd3);
        check("t2_overrun", {48'b0, overrun_count}, 64'd2);

        // Test 3: busy never rises
        do_reset();
        busy_en = 1'b0;
        ch_mask = 4'b0001;
        push_frame(16'h8001, 16'h8000, 16'h8000, 16'h8000);
        send(0, 16'h0001);
        tick(1);
        check("t3_start", {63'b0, dac_start}, 64'd1);
        tick(255);
        check("t3_timeout_early", {63'b0, timeout_err}, 64'd0);
        check("t3_waiting", {63'b0, state_idle}, 64'd0);
        tick(1);
        check("t3_timeout", {63'b0, timeout_err}, 64'd1);
        check("t3_idle", {63'b0, state_idle}, 64'd1);
        check("t3_frames", {32'b0, frame_count}, 64'd0);
        busy_en = 1'b1;
        push_frame(16'h8002, 16'h8000, 16'h8000, 16'h8000);
        send(0, 16'h0002);
        wait_frames(1, 200);
        check("t3_frames_after", {32'b0, frame_count}, 64'd1);
        check("t3_timeout_sticky", {63'b0, timeout_err}, 64'd1);

        // Overrun: +4 per cycle, saturating
        do_reset();
        ch_mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            v[i] = 1'b1;
            d[i] = 16'(i);
        end
        tick(3);
        check("ovr_plus4", {48'b0, overrun_count}, 64'd8);
        tick(16400);
        check("ovr_saturate", {48'b0, overrun_count}, 64'hFFFF);
        for (int i = 0; i < 4; i++) v[i] = 1'b0;
        tick(2);

        // Test 5: ch2 sample in the snapshot cycle
        do_reset();
        ch_mask = 4'b0101;
        push_frame(16'h8100, 16'h8000, 16'h8000, 16'h8000);
        push_frame(16'h8100, 16'h8000, 16'hFFFF, 16'h8000);
        v[0] = 1'b1;
        d[0] = 16'h0100;
        tick(1);
        v[0] = 1'b0;
        v[2] = 1'b1;
        d[2] = 16'h7FFF;
        tick(1);
        v[2] = 1'b0;
        check("t5_start", {63'b0, dac_start}, 64'd1);
        wait_frames(2, 300);
        check("t5_frames", {32'b0, frame_count}, 64'd2);

        // Test 4: hold-off spacing with continuous ch0 samples
        do_reset();
        ch_mask = 4'b0001;
        min_interval = 16'd100;
        n0 = starts.size();
        for (int i = 0; i < 3; i++) push_frame(16'h8042, 16'h8000, 16'h8000, 16'h8000);
        v[0] = 1'b1;
        d[0] = 16'h0042;
        for (int i = 0; i < 600 && starts.size() < n0 + 3; i++) tick(1);
        v[0] = 1'b0;
        tick(1);
        check("t4_launches", 64'(starts.size() - n0), 64'd3);
        if (starts.size() >= n0 + 3) begin
            check("t4_spacing1", 64'(starts[n0+1] - starts[n0]), 64'd143);
            check("t4_spacing2", 64'(starts[n0+2] - starts[n0+1]), 64'd143);
        end
        tick(10);
        check("t4_in_frame", {63'b0, state_idle}, 64'd0);
        check("t4_frames", {32'b0, frame_count}, 64'd2);

        // Test 6: reset during BUSY
        reset_n = 1'b0;
        #1;
        check("t6_start", {63'b0, dac_start}, 64'd0);
        check("t6_idle", {63'b0, state_idle}, 64'd1);
        check("t6_dac", {dac3_datain, dac2_datain, dac1_datain, dac0_datain}, 64'h8000_8000_8000_8000);
        check("t6_frames", {32'b0, frame_count}, 64'd0);
        check("t6_overrun", {48'b0, overrun_count}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        min_interval = 16'd0;
        n0 = starts.size();
        tick(30);
        check("t6_no_launch", 64'(starts.size() - n0), 64'd0);

        // Enable low: samples accumulate, launch only once enabled
        enable = 1'b0;
        send(0, 16'h00AA);
        tick(20);
        check("en_low_no_launch", 64'(starts.size() - n0), 64'd0);
        push_frame(16'h80AA, 16'h8000, 16'h8000, 16'h8000);
        enable = 1'b1;
        wait_frames(1, 200);
        check("en_frames", {32'b0, frame_count}, 64'd1);
        check("all_frames_seen", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
